// File: rtl/conv2_window_sched_pkg.sv
// Shared types and defaults for the conv2 window scheduler.
// Holds the FSM state encoding and the sizing helper used by the interface and the RTL.
package conv2_window_sched_pkg;

    localparam int DEF_IMG_W = 12;
    localparam int DEF_IMG_H = 12;
    localparam int DEF_KS    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } schedState_t;

    // A single weight group still needs a one-bit select.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2_window_sched_if.sv
// Pixel-stream handshake, datapath issue and result signals of the conv2 scheduler.
// The master modport is the scheduler side; slave is the upstream/datapath side.
interface conv2_window_sched_if
    import conv2_window_sched_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int N_GROUP = 1
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int GW = selWidth(N_GROUP);

    logic          start;
    logic          pixValid;
    logic          pixReady;
    logic          winValid;
    logic [GW-1:0] wgtSel;
    logic          outValid;
    logic [RW-1:0] outRow;
    logic [CW-1:0] outCol;
    logic [GW-1:0] outGrp;
    logic          busy;
    logic          done;

    modport master (
        input  start, pixValid,
        output pixReady, winValid, wgtSel, outValid, outRow, outCol, outGrp, busy, done
    );

    modport slave (
        output start, pixValid,
        input  pixReady, winValid, wgtSel, outValid, outRow, outCol, outGrp, busy, done
    );

endinterface

// File: rtl/conv2_window_sched_delay_line.sv
// Fixed-latency shift register aligning issued windows with the registered PE sums.
// The MSB of each word is its valid flag; o_pending flags valids that survive the next edge.
module conv2_window_sched_delay_line
    import conv2_window_sched_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_pending
);
    // Every stage except the output one still holds work after the next edge.
    localparam logic [DEPTH-1:0] EARLY_MASK = DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] w_valid;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_comb begin
        w_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_valid[k] = r_stage[k][WIDTH-1];
        end
    end

    assign o_data    = r_stage[DEPTH-1];
    assign o_pending = |(w_valid & EARLY_MASK);

endmodule

// File: rtl/conv2_window_sched.sv
// Sequencer for the conv2 5x5 datapath: tracks the raster position of the pool1 stream,
// issues each complete window once per weight group and aligns results with PE latency.
module conv2_window_sched
    import conv2_window_sched_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int KS      = DEF_KS,
    parameter int N_GROUP = 1,
    parameter int PE_LAT  = 1
) (
    input  logic clk,
    input  logic rst,
    conv2_window_sched_if.master bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int GW = selWidth(N_GROUP);
    localparam int DW = 1 + RW + CW + GW;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KS - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KS - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUP - 1);

    schedState_t   r_state;
    schedState_t   w_nextState;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_issuing;
    logic [GW-1:0] r_grp;
    logic [RW-1:0] r_winRow;
    logic [CW-1:0] r_winCol;

    logic          w_pixReady;
    logic          w_accept;
    logic          w_winDone;
    logic          w_lastPix;
    logic          w_busy;
    logic          w_done;
    logic          w_pending;
    logic [DW-1:0] w_dlOut;

    // Upstream may only advance once the current window is on its last group.
    assign w_pixReady = (r_state == ST_SCAN) && (!r_issuing || (r_grp == GRP_LAST));
    assign w_accept   = bus.pixValid && w_pixReady;
    assign w_winDone  = w_accept && (r_row >= ROW_WIN) && (r_col >= COL_WIN);
    assign w_lastPix  = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nextState = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_busy = 1'b1;
                if (w_lastPix) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                // The result leaving the delay line this cycle is the last one.
                if (!r_issuing && !w_pending) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Window coordinates stay latched until the last group of that window has gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issuing <= 1'b0;
            r_grp     <= '0;
            r_winRow  <= '0;
            r_winCol  <= '0;
        end else if (w_winDone) begin
            r_issuing <= 1'b1;
            r_grp     <= '0;
            r_winRow  <= r_row - ROW_WIN;
            r_winCol  <= r_col - COL_WIN;
        end else if (r_issuing) begin
            if (r_grp == GRP_LAST) begin
                r_issuing <= 1'b0;
                r_grp     <= '0;
            end else begin
                r_grp <= r_grp + GW'(1);
            end
        end
    end

    conv2_window_sched_delay_line #(
        .DEPTH (PE_LAT),
        .WIDTH (DW)
    ) u_delay (
        .clk       (clk),
        .i_clear   (rst),
        .i_data    ({r_issuing, r_winRow, r_winCol, r_grp}),
        .o_data    (w_dlOut),
        .o_pending (w_pending)
    );

    assign bus.pixReady = w_pixReady;
    assign bus.winValid = r_issuing;
    assign bus.wgtSel   = r_grp;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign {bus.outValid, bus.outRow, bus.outCol, bus.outGrp} = w_dlOut;

endmodule

// File: tb/tb_conv2_window_sched.sv
// Randomised self-checking bench for conv2_window_sched with N_GROUP=1/PE_LAT=1 and N_GROUP=3/PE_LAT=2.
// A queue-based model of accepted pixels, window issues and delayed results predicts every cycle.
module tb_conv2_window_sched;

    localparam int IMG_W = 12;
    localparam int IMG_H = 12;
    localparam int KS    = 5;
    localparam int OW    = IMG_W - KS + 1;
    localparam int OH    = IMG_H - KS + 1;
    localparam int BIG   = 1 << 30;

    typedef struct {
        int row;
        int col;
        int grp;
        int due;
    } rec_t;

    logic clk;
    logic rst;
    logic start;
    logic pixValid;
    bit   cfg;
    int   nGroup;
    int   peLat;

    conv2_window_sched_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .N_GROUP(1)) bus1 ();
    conv2_window_sched_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .N_GROUP(3)) bus3 ();

    conv2_window_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KS(KS), .N_GROUP(1), .PE_LAT(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    conv2_window_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KS(KS), .N_GROUP(3), .PE_LAT(2)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    assign bus1.start    = cfg ? 1'b0 : start;
    assign bus1.pixValid = cfg ? 1'b0 : pixValid;
    assign bus3.start    = cfg ? start : 1'b0;
    assign bus3.pixValid = cfg ? pixValid : 1'b0;

    logic obsReady, obsWin, obsOut, obsBusy, obsDone;
    int   obsSel, obsRow, obsCol, obsGrp;

    assign obsReady = cfg ? bus3.pixReady : bus1.pixReady;
    assign obsWin   = cfg ? bus3.winValid : bus1.winValid;
    assign obsOut   = cfg ? bus3.outValid : bus1.outValid;
    assign obsBusy  = cfg ? bus3.busy     : bus1.busy;
    assign obsDone  = cfg ? bus3.done     : bus1.done;
    assign obsSel   = cfg ? int'(bus3.wgtSel) : int'(bus1.wgtSel);
    assign obsRow   = cfg ? int'(bus3.outRow) : int'(bus1.outRow);
    assign obsCol   = cfg ? int'(bus3.outCol) : int'(bus1.outCol);
    assign obsGrp   = cfg ? int'(bus3.outGrp) : int'(bus1.outGrp);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vecCount  = 0;
    int   missCount = 0;
    int   cyc       = 0;
    rec_t issueQ[$];
    rec_t outQ[$];
    int   accCount, resCount, expDoneCycle, acc53Cycle, firstWinCycle;
    int   lastOutObs, doneObs, doneCount;
    bit   started, inScan, pendStart, frameDone;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic clearModel();
        issueQ.delete();
        outQ.delete();
        accCount      = 0;
        resCount      = 0;
        expDoneCycle  = BIG;
        acc53Cycle    = -1;
        firstWinCycle = -1;
        lastOutObs    = -1;
        doneObs       = -1;
        doneCount     = 0;
        started       = 1'b0;
        inScan        = 1'b0;
        pendStart     = 1'b0;
        frameDone     = 1'b0;
    endtask

    // One clock of stimulus: check the cycle's outputs against the model, then drive inputs.
    task automatic applyStimulus(input bit st, input bit pv);
        rec_t e;
        bit   expReady;
        int   r, c;
        @(negedge clk);
        cyc++;
        if (pendStart) begin
            started   = 1'b1;
            inScan    = 1'b1;
            pendStart = 1'b0;
        end
        expReady = inScan && (issueQ.size() <= 1);
        checkOutput("pixReady", int'(obsReady), int'(expReady));

        if (outQ.size() > 0 && outQ[0].due == cyc) begin
            e = outQ.pop_front();
            checkOutput("outValid", int'(obsOut), 1);
            checkOutput("outRow", obsRow, e.row);
            checkOutput("outCol", obsCol, e.col);
            checkOutput("outGrp", obsGrp, e.grp);
            resCount++;
            if (resCount == OW * OH * nGroup) expDoneCycle = cyc + 1;
        end else begin
            checkOutput("outValid", int'(obsOut), 0);
        end

        if (issueQ.size() > 0) begin
            e = issueQ.pop_front();
            checkOutput("winValid", int'(obsWin), 1);
            checkOutput("wgtSel", obsSel, e.grp);
            e.due = cyc + peLat;
            outQ.push_back(e);
        end else begin
            checkOutput("winValid", int'(obsWin), 0);
        end

        checkOutput("busy", int'(obsBusy), int'(started && cyc < expDoneCycle));
        checkOutput("done", int'(obsDone), int'(cyc == expDoneCycle));
        if (cyc == expDoneCycle) begin
            started      = 1'b0;
            frameDone    = 1'b1;
            expDoneCycle = BIG;
        end

        if (obsOut) lastOutObs = cyc;
        if (obsDone) begin
            doneObs = cyc;
            doneCount++;
        end
        if (obsWin && firstWinCycle < 0) firstWinCycle = cyc;

        start    = st;
        pixValid = pv;
        if (st && !started && !pendStart) pendStart = 1'b1;
        if (pv && expReady) begin
            r = accCount / IMG_W;
            c = accCount % IMG_W;
            accCount++;
            if (accCount == 53) acc53Cycle = cyc;
            if (r >= KS - 1 && c >= KS - 1) begin
                for (int g = 0; g < nGroup; g++) begin
                    issueQ.push_back('{row: r - (KS - 1), col: c - (KS - 1), grp: g, due: 0});
                end
            end
            if (accCount == IMG_W * IMG_H) inScan = 1'b0;
        end
    endtask

    task automatic resetDut(input int n, input bit st);
        rst      = 1'b1;
        start    = st;
        pixValid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            checkOutput("rstPixReady", int'(obsReady), 0);
            checkOutput("rstWinValid", int'(obsWin), 0);
            checkOutput("rstWgtSel", obsSel, 0);
            checkOutput("rstOutValid", int'(obsOut), 0);
            checkOutput("rstOutRow", obsRow, 0);
            checkOutput("rstOutCol", obsCol, 0);
            checkOutput("rstOutGrp", obsGrp, 0);
            checkOutput("rstBusy", int'(obsBusy), 0);
            checkOutput("rstDone", int'(obsDone), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        clearModel();
    endtask

    // Runs one frame; a nonzero rstAt aborts it with a reset right after that acceptance.
    task automatic runFrame(input bit gaps, input int rstAt, input int startBusyStep);
        int n;
        bit pv;
        clearModel();
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!frameDone && n < 3000) begin
            pv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(n == startBusyStep, pv);
            n++;
            if (rstAt > 0 && accCount == rstAt) break;
        end
        if (rstAt > 0) begin
            @(negedge clk);
            cyc++;
            rst      = 1'b1;
            pixValid = 1'b0;
            start    = 1'b0;
            @(negedge clk);
            cyc++;
            checkOutput("midRstBusy", int'(obsBusy), 0);
            checkOutput("midRstOutValid", int'(obsOut), 0);
            checkOutput("midRstWinValid", int'(obsWin), 0);
            checkOutput("midRstPixReady", int'(obsReady), 0);
            rst = 1'b0;
            clearModel();
        end else begin
            checkOutput("frameFinished", int'(frameDone), 1);
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0);
            checkOutput("resultCount", resCount, OW * OH * nGroup);
            checkOutput("firstWinLatency", firstWinCycle - acc53Cycle, 1);
            checkOutput("doneAfterLastOut", doneObs - lastOutObs, 1);
            checkOutput("donePulses", doneCount, 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pixValid = 1'b0;
        cfg      = 1'b0;
        nGroup   = 1;
        peLat    = 1;
        clearModel();

        resetDut(3, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);

        runFrame(1'b0, 0, -1);
        runFrame(1'b1, 0, -1);
        runFrame(1'b0, 70, 20);
        runFrame(1'b0, 0, 35);

        cfg    = 1'b1;
        nGroup = 3;
        peLat  = 2;
        resetDut(2, 1'b0);
        runFrame(1'b0, 0, -1);
        runFrame(1'b1, 0, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
